// File: rtl/udma_filter_binpack.sv
// udma_filter_binpack
// Sink for the binarized filter stream. Bit 0 of each accepted beat is packed
// LSB-first into a DATA_WIDTH-bit word. Each completed (or eof-truncated) word
// is written to L2 through a req/gnt port at auto-incrementing word addresses.
module udma_filter_binpack #(
    parameter int DATA_WIDTH = 32,
    parameter int TRANS_SIZE = 16,
    parameter int L2_AWIDTH  = 18
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [L2_AWIDTH-1:0]    cfg_start_addr_i,
    input  logic [TRANS_SIZE-1:0]   cfg_size_i,
    input  logic                    cmd_start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [TRANS_SIZE-1:0]   words_o,
    input  logic [DATA_WIDTH-1:0]   input_data_i,
    input  logic [1:0]              input_datasize_i,
    input  logic                    input_valid_i,
    input  logic                    input_sof_i,
    input  logic                    input_eof_i,
    output logic                    input_ready_o,
    output logic                    wr_req_o,
    input  logic                    wr_gnt_i,
    output logic [L2_AWIDTH-1:0]    wr_addr_o,
    output logic [DATA_WIDTH-1:0]   wr_data_o,
    output logic [DATA_WIDTH/8-1:0] wr_be_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PACK,
        ST_WRITE
    } state_t;

    state_t                  state;
    logic [L2_AWIDTH-1:0]    addr_r;
    logic [TRANS_SIZE-1:0]   size_r;
    logic [TRANS_SIZE-1:0]   words_r;
    logic [DATA_WIDTH-1:0]   word_r;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    eof_seen;
    logic                    busy_r;
    logic                    done_r;
    logic                    ready_r;
    logic                    req_r;

    logic                    accept;
    logic                    grant;
    logic                    last_word;

    // Only data bit 0 carries information; the rest of the beat is don't-care.
    logic                    unused_inputs;
    assign unused_inputs = ^{input_datasize_i, input_sof_i, input_data_i[DATA_WIDTH-1:1]};

    // ready_r is high exactly while in PACK, req_r exactly while in WRITE.
    assign accept    = ready_r & input_valid_i;
    assign grant     = req_r & wr_gnt_i;
    // The word being granted ends the transfer on a seen eof or on the size limit.
    assign last_word = eof_seen |
                       ((size_r != '0) && ((words_r + TRANS_SIZE'(1)) == size_r));

    assign busy_o        = busy_r;
    assign done_o        = done_r;
    assign words_o       = words_r;
    assign input_ready_o = ready_r;
    assign wr_req_o      = req_r;
    assign wr_addr_o     = addr_r;
    assign wr_data_o     = word_r;
    assign wr_be_o       = '1;

    // Transfer FSM: packs accepted bits, then holds the word on the write port until granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            addr_r   <= '0;
            size_r   <= '0;
            words_r  <= '0;
            word_r   <= '0;
            bit_cnt  <= '0;
            eof_seen <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ready_r  <= 1'b0;
            req_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_start_i) begin
                        addr_r   <= {cfg_start_addr_i[L2_AWIDTH-1:2], 2'b00};
                        size_r   <= cfg_size_i;
                        words_r  <= '0;
                        word_r   <= '0;
                        bit_cnt  <= '0;
                        eof_seen <= 1'b0;
                        busy_r   <= 1'b1;
                        ready_r  <= 1'b1;
                        state    <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (accept) begin
                        word_r[bit_cnt] <= input_data_i[0];
                        bit_cnt         <= bit_cnt + CNT_W'(1);
                        if ((bit_cnt == CNT_W'(DATA_WIDTH - 1)) || input_eof_i) begin
                            eof_seen <= input_eof_i;
                            ready_r  <= 1'b0;
                            req_r    <= 1'b1;
                            state    <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (grant) begin
                        addr_r  <= addr_r + L2_AWIDTH'(4);
                        words_r <= words_r + TRANS_SIZE'(1);
                        word_r  <= '0;
                        bit_cnt <= '0;
                        req_r   <= 1'b0;
                        if (last_word) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            ready_r <= 1'b1;
                            state   <= ST_PACK;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udma_filter_binpack.sv
// Testbench for udma_filter_binpack: table of transfers plus hand-written
// sequences for grant stall, mid-write reset and start-while-busy.
module tb_udma_filter_binpack;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [17:0] cfg_start_addr_i;
    logic [15:0] cfg_size_i;
    logic        cmd_start_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] words_o;
    logic [31:0] input_data_i;
    logic [1:0]  input_datasize_i;
    logic        input_valid_i;
    logic        input_sof_i;
    logic        input_eof_i;
    logic        input_ready_o;
    logic        wr_req_o;
    logic        wr_gnt_i;
    logic [17:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_be_o;

    always #5 clk = ~clk;

    udma_filter_binpack #(.DATA_WIDTH(32), .TRANS_SIZE(16), .L2_AWIDTH(18)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .cfg_start_addr_i (cfg_start_addr_i),
        .cfg_size_i       (cfg_size_i),
        .cmd_start_i      (cmd_start_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .words_o          (words_o),
        .input_data_i     (input_data_i),
        .input_datasize_i (input_datasize_i),
        .input_valid_i    (input_valid_i),
        .input_sof_i      (input_sof_i),
        .input_eof_i      (input_eof_i),
        .input_ready_o    (input_ready_o),
        .wr_req_o         (wr_req_o),
        .wr_gnt_i         (wr_gnt_i),
        .wr_addr_o        (wr_addr_o),
        .wr_data_o        (wr_data_o),
        .wr_be_o          (wr_be_o)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int gnt_mode = 0;  // 0: always grant, 1: random grant, 2: never grant

    typedef struct packed {
        logic [17:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    typedef struct {
        logic [17:0] addr;
        logic [15:0] size;
        int          gmode;
        int          nbeats;
        logic [63:0] bits;
        int          eof_at;
        int          exp_n;
        logic [17:0] a0;
        logic [31:0] d0;
        logic [17:0] a1;
        logic [31:0] d1;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Grant driver, changes away from the sampling edge.
    initial begin
        wr_gnt_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (gnt_mode)
                0:       wr_gnt_i = 1'b1;
                1:       wr_gnt_i = 1'($urandom_range(0, 1));
                default: wr_gnt_i = 1'b0;
            endcase
        end
    end

    // Write-port monitor: pops the scoreboard on every handshake.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (done_o) done_cnt++;
                if (wr_req_o && wr_gnt_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                                 wr_addr_o, wr_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 64'(wr_addr_o), 64'(e.addr));
                        chk("wr_data", 64'(wr_data_o), 64'(e.data));
                        chk("wr_be", 64'(wr_be_o), 64'h0F);
                    end
                end
            end
        end
    end

    task automatic start(input logic [17:0] addr, input logic [15:0] size);
        cfg_start_addr_i = addr;
        cfg_size_i       = size;
        cmd_start_i      = 1'b1;
        @(posedge clk);
        #1;
        cmd_start_i = 1'b0;
    endtask

    task automatic send_beat(input logic b, input logic e);
        logic acc;
        input_data_i     = $urandom;
        input_data_i[0]  = b;
        input_datasize_i = 2'($urandom_range(0, 3));
        input_sof_i      = 1'($urandom_range(0, 1));
        input_eof_i      = e;
        input_valid_i    = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = input_ready_o;
            @(posedge clk);
            #1;
        end
        if (!acc) fail_now("beat_accept");
        input_valid_i = 1'b0;
        input_eof_i   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 600) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (done_cnt == 0) fail_now(name);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_ready_low(input string name);
        input_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk(name, 64'(input_ready_o), 64'h0);
        end
        @(posedge clk);
        #1;
        input_valid_i = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        rst_i            = 1'b1;
        cfg_start_addr_i = '0;
        cfg_size_i       = '0;
        cmd_start_i      = 1'b0;
        input_data_i     = '0;
        input_datasize_i = '0;
        input_valid_i    = 1'b0;
        input_sof_i      = 1'b0;
        input_eof_i      = 1'b0;

        // addr, size, gnt mode, beats, bits, eof beat, writes, a0, d0, a1, d1
        vecs[0] = '{18'h00100, 16'd2, 0, 64, 64'h5555_5555_5555_5555, -1, 2,
                    18'h00100, 32'h5555_5555, 18'h00104, 32'h5555_5555};
        vecs[1] = '{18'h00200, 16'd0, 1, 5, 64'h0000_0000_0000_001B, 4, 1,
                    18'h00200, 32'h0000_001B, 18'h0, 32'h0};
        vecs[2] = '{18'h00300, 16'd0, 0, 32, 64'h0000_0000_FFFF_FFFF, 31, 1,
                    18'h00300, 32'hFFFF_FFFF, 18'h0, 32'h0};
        vecs[3] = '{18'h000FE, 16'd1, 1, 32, 64'h0000_0000_DEAD_BEEF, -1, 1,
                    18'h000FC, 32'hDEAD_BEEF, 18'h0, 32'h0};
        vecs[4] = '{18'h3FFFC, 16'd0, 1, 36, 64'h0000_000A_1234_5678, 35, 2,
                    18'h3FFFC, 32'h1234_5678, 18'h00000, 32'h0000_000A};

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_done", 64'(done_o), 64'h0);
        chk("rst_ready", 64'(input_ready_o), 64'h0);
        chk("rst_req", 64'(wr_req_o), 64'h0);
        chk("rst_words", 64'(words_o), 64'h0);
        chk("rst_addr", 64'(wr_addr_o), 64'h0);
        chk("rst_data", 64'(wr_data_o), 64'h0);
        @(posedge clk);
        #1;

        // Table-driven transfers
        for (int v = 0; v < 5; v++) begin
            gnt_mode = vecs[v].gmode;
            done_cnt = 0;
            exp_q.push_back('{vecs[v].a0, vecs[v].d0});
            if (vecs[v].exp_n > 1) exp_q.push_back('{vecs[v].a1, vecs[v].d1});
            start(vecs[v].addr, vecs[v].size);
            chk("start_busy", 64'(busy_o), 64'h1);
            for (int i = 0; i < vecs[v].nbeats; i++)
                send_beat(vecs[v].bits[i], (i == vecs[v].eof_at));
            wait_done("vec_done");
            chk("vec_done_cnt", 64'(done_cnt), 64'h1);
            chk("vec_busy_end", 64'(busy_o), 64'h0);
            chk("vec_words", 64'(words_o), 64'(vecs[v].exp_n));
            chk("vec_q_empty", 64'(exp_q.size()), 64'h0);
            check_ready_low("vec_ready_idle");
        end

        // Grant held low for 10 cycles during WRITE, then more beats
        gnt_mode = 2;
        done_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back('{18'h00400, 32'hCAFE_F00D});
        exp_q.push_back('{18'h00404, 32'h0000_0005});
        start(18'h00400, 16'd0);
        for (int i = 0; i < 32; i++) begin
            logic [31:0] pat;
            pat = 32'hCAFE_F00D;
            send_beat(pat[i], 1'b0);
        end
        repeat (10) begin
            @(negedge clk);
            chk("stall_req", 64'(wr_req_o), 64'h1);
            chk("stall_addr", 64'(wr_addr_o), 64'h400);
            chk("stall_data", 64'(wr_data_o), 64'hCAFE_F00D);
            chk("stall_ready", 64'(input_ready_o), 64'h0);
        end
        @(posedge clk);
        #1;
        gnt_mode = 0;
        send_beat(1'b1, 1'b0);
        send_beat(1'b0, 1'b0);
        send_beat(1'b1, 1'b1);
        wait_done("stall_done");
        chk("stall_done_cnt", 64'(done_cnt), 64'h1);
        chk("stall_words", 64'(words_o), 64'h2);
        chk("stall_q_empty", 64'(exp_q.size()), 64'h0);

        // Reset while a write is pending
        gnt_mode = 2;
        done_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        start(18'h00500, 16'd0);
        for (int i = 0; i < 32; i++) send_beat(1'b1, 1'b0);
        @(negedge clk);
        chk("pre_rst_req", 64'(wr_req_o), 64'h1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i    = 1'b0;
        gnt_mode = 0;
        @(negedge clk);
        chk("mid_rst_req", 64'(wr_req_o), 64'h0);
        chk("mid_rst_busy", 64'(busy_o), 64'h0);
        chk("mid_rst_ready", 64'(input_ready_o), 64'h0);
        chk("mid_rst_words", 64'(words_o), 64'h0);
        chk("mid_rst_addr", 64'(wr_addr_o), 64'h0);
        chk("mid_rst_data", 64'(wr_data_o), 64'h0);
        chk("mid_rst_done", 64'(done_o), 64'h0);
        @(posedge clk);
        #1;
        done_cnt = 0;
        exp_q.push_back('{18'h00000, 32'h0000_0001});
        start(18'h00003, 16'd0);
        send_beat(1'b1, 1'b1);
        wait_done("unaligned_done");
        chk("unaligned_words", 64'(words_o), 64'h1);
        chk("unaligned_q_empty", 64'(exp_q.size()), 64'h0);

        // Start pulse while busy must not re-latch configuration
        done_cnt = 0;
        gnt_mode = 1;
        exp_q.push_back('{18'h00600, 32'h0F0F_00FF});
        exp_q.push_back('{18'h00604, 32'h0000_0001});
        start(18'h00600, 16'd0);
        for (int i = 0; i < 32; i++) begin
            logic [31:0] pat;
            pat = 32'h0F0F_00FF;
            if (i == 10) begin
                start(18'h00700, 16'd1);
                chk("busy_restart", 64'(busy_o), 64'h1);
            end
            send_beat(pat[i], 1'b0);
        end
        send_beat(1'b1, 1'b1);
        wait_done("restart_done");
        chk("restart_done_cnt", 64'(done_cnt), 64'h1);
        chk("restart_words", 64'(words_o), 64'h2);
        chk("restart_q_empty", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
